// File: rtl/rs485_pkg.sv
// Shared types and helpers for the RS485 diagnostic receiver.
// Parity support in the receiver is compiled in with RS485_PARITY_EN.
package rs485_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // 1'b0 selects even parity, 1'b1 odd parity
  localparam logic PARITY_ODD = 1'b0;

  typedef struct packed {
    logic frame;
    logic parity;
    logic overrun;
  } rx_err_t;

  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    longint den;
    longint quo;
    den = longint'(baud) * longint'(os);
    quo = (longint'(clk_hz) + (den / 64'sd2)) / den;
    return (quo < 64'sd1) ? 32'sd1 : int'(quo);
  endfunction

  function automatic logic parity_ok(input logic [7:0] data, input logic pbit);
    return ((^data) ^ pbit) == PARITY_ODD;
  endfunction

endpackage

// File: rtl/rs485_sync_sampler.sv
// Line synchroniser, oversampling tick divider and 3-sample majority voter.
module rs485_sync_sampler #(
  parameter int DIV         = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic serial,
  input  logic restart,
  output logic sample_tick,
  output logic mid_tick,
  output logic bit_value,
  output logic fall_edge
);
  localparam int CW = (DIV > 32'sd1) ? $clog2(DIV) : 32'sd1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 32'sd1);
  localparam logic [TW-1:0] MID_IDX  = TW'((OVERSAMPLE / 32'sd2) + 32'sd1);
  localparam logic [TW-1:0] BIT_LAST = TW'(OVERSAMPLE - 32'sd1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CW-1:0]          div_cnt_r;
  logic [TW-1:0]          bit_tick_r;
  logic [1:0]             hist_r;
  logic                   line_s;

  assign line_s      = sync_r[SYNC_STAGES-1];
  assign sample_tick = (div_cnt_r == {CW{1'b0}});
  // hist_r plus the live sample form the 3-deep window voted at the mid tick
  assign mid_tick    = sample_tick && (bit_tick_r == MID_IDX);
  assign bit_value   = (hist_r[1] & hist_r[0]) | (hist_r[1] & line_s) | (hist_r[0] & line_s);
  assign fall_edge   = sample_tick & hist_r[0] & ~line_s;

  // Synchroniser, tick divider, tick-in-bit position and sample history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r     <= {SYNC_STAGES{1'b1}};
      div_cnt_r  <= DIV_LAST;
      bit_tick_r <= {TW{1'b0}};
      hist_r     <= 2'b11;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], serial};
      if (restart || sample_tick) begin
        div_cnt_r <= DIV_LAST;
      end else begin
        div_cnt_r <= div_cnt_r - CW'(1'b1);
      end
      if (restart) begin
        bit_tick_r <= {TW{1'b0}};
      end else if (sample_tick) begin
        bit_tick_r <= (bit_tick_r == BIT_LAST) ? {TW{1'b0}} : bit_tick_r + TW'(1'b1);
      end
      if (sample_tick) begin
        hist_r <= {hist_r[0], line_s};
      end
    end
  end

endmodule

// File: rtl/rs485_uart_rx.sv
// RS485 diagnostic-link receiver: 8-bit LSB-first frames to a valid/ready byte stream.
// Define RS485_PARITY_EN to expect a parity bit between data and stop.
module rs485_uart_rx
  import rs485_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 120000000,
  parameter int BAUD        = 115200,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rs485_pl_di,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        frame_err_o,
  output logic        parity_err_o,
  output logic        overrun_o,
  output logic [15:0] err_cnt_o,
  output logic        busy_o
);
  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);

  rx_state_t   state_r, state_next_s;
  logic        sample_tick_s, mid_tick_s, bit_value_s, fall_edge_s, restart_s;
  logic [7:0]  shift_r, data_r;
  logic [2:0]  bit_cnt_r;
  logic        brk_r, brk_next_s, valid_r, busy_r, deliver_s, par_ok_s;
  rx_err_t     err_next_s, err_r;
  logic [15:0] err_cnt_r;

  assign restart_s = (state_r == IDLE) && fall_edge_s;

  rs485_sync_sampler #(
    .DIV         (DIV),
    .OVERSAMPLE  (OVERSAMPLE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .clk         (clk),
    .reset_n     (reset_n),
    .serial      (rs485_pl_di),
    .restart     (restart_s),
    .sample_tick (sample_tick_s),
    .mid_tick    (mid_tick_s),
    .bit_value   (bit_value_s),
    .fall_edge   (fall_edge_s)
  );

`ifdef RS485_PARITY_EN
  logic par_bit_r;
  assign par_ok_s = parity_ok(shift_r, par_bit_r);

  // Captured parity bit of the current frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_bit_r <= 1'b0;
    end else if ((state_r == PARITY) && mid_tick_s) begin
      par_bit_r <= bit_value_s;
    end
  end
`else
  assign par_ok_s = 1'b1;
`endif

  // Next-state, delivery and error decode
  always_comb begin
    state_next_s = state_r;
    brk_next_s   = 1'b0;
    deliver_s    = 1'b0;
    err_next_s   = rx_err_t'(3'b000);
    case (state_r)
      IDLE: begin
        if (fall_edge_s) state_next_s = START;
        else             state_next_s = IDLE;
      end
      START: begin
        if (mid_tick_s && bit_value_s) state_next_s = IDLE;
        else if (mid_tick_s)           state_next_s = DATA;
        else                           state_next_s = START;
      end
      DATA: begin
        if (mid_tick_s && (bit_cnt_r == 3'd7)) begin
`ifdef RS485_PARITY_EN
          state_next_s = PARITY;
`else
          state_next_s = STOP;
`endif
        end else begin
          state_next_s = DATA;
        end
      end
      PARITY: begin
`ifdef RS485_PARITY_EN
        if (mid_tick_s) state_next_s = STOP;
        else            state_next_s = PARITY;
`else
        state_next_s = IDLE;
`endif
      end
      STOP: begin
        // After a low stop bit, hold here until the line is high again
        if (brk_r) begin
          if (sample_tick_s && bit_value_s) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = STOP;
            brk_next_s   = 1'b1;
          end
        end else if (mid_tick_s) begin
          err_next_s.parity = !par_ok_s;
          if (!bit_value_s) begin
            err_next_s.frame = 1'b1;
            state_next_s     = STOP;
            brk_next_s       = 1'b1;
          end else begin
            deliver_s    = par_ok_s;
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = STOP;
        end
      end
      default: state_next_s = IDLE;
    endcase
    err_next_s.overrun = deliver_s && valid_r && !ready_i;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_next_s;
  end

  // Shift register, bit counter, break flag and busy flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_r   <= 8'h00;
      bit_cnt_r <= 3'd0;
      brk_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      brk_r  <= brk_next_s;
      busy_r <= (state_next_s != IDLE);
      if (state_r == START) begin
        bit_cnt_r <= 3'd0;
      end else if ((state_r == DATA) && mid_tick_s) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
        shift_r   <= {bit_value_s, shift_r[7:1]};
      end
    end
  end

  // Output holding register, error pulses and saturating error count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_r    <= 8'h00;
      valid_r   <= 1'b0;
      err_r     <= rx_err_t'(3'b000);
      err_cnt_r <= 16'h0000;
    end else begin
      err_r <= err_next_s;
      if (deliver_s && !err_next_s.overrun) begin
        data_r  <= shift_r;
        valid_r <= 1'b1;
      end else if (valid_r && ready_i) begin
        valid_r <= 1'b0;
      end
      if ((|{err_next_s.frame, err_next_s.parity, err_next_s.overrun}) && (err_cnt_r != 16'hFFFF)) begin
        err_cnt_r <= err_cnt_r + 16'd1;
      end
    end
  end

  assign data_o       = data_r;
  assign valid_o      = valid_r;
  assign frame_err_o  = err_r.frame;
  assign parity_err_o = err_r.parity;
  assign overrun_o    = err_r.overrun;
  assign err_cnt_o    = err_cnt_r;
  assign busy_o       = busy_r;

endmodule

// File: tb/tb_rs485_uart_rx.sv
// Directed bench for rs485_uart_rx at 16 clk per bit; parity cases need RS485_PARITY_EN.
module tb_rs485_uart_rx;
  import rs485_pkg::*;

`ifdef RS485_PARITY_EN
  localparam bit WITH_PAR = 1'b1;
`else
  localparam bit WITH_PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        line = 1'b1;
  logic        ready = 1'b0;
  logic [7:0]  data_o;
  logic        valid_o, frame_err_o, parity_err_o, overrun_o, busy_o;
  logic [15:0] err_cnt_o;

  int n_cmp = 0, n_mis = 0;
  int n_ferr = 0, n_perr = 0, n_ovr = 0, n_acc = 0;
  int b_ferr, b_perr, b_ovr, b_acc;
  logic [7:0] last_acc = 8'h00;

  always #5 clk = ~clk;

  rs485_uart_rx #(
    .CLK_FREQ_HZ (16000000),
    .BAUD        (1000000),
    .OVERSAMPLE  (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rs485_pl_di  (line),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o),
    .overrun_o    (overrun_o),
    .err_cnt_o    (err_cnt_o),
    .busy_o       (busy_o)
  );

  // Pulse and handshake monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (frame_err_o)  n_ferr++;
    if (parity_err_o) n_perr++;
    if (overrun_o)    n_ovr++;
    if (valid_o && ready) begin
      n_acc++;
      last_acc = data_o;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic snap();
    b_ferr = n_ferr;
    b_perr = n_perr;
    b_ovr  = n_ovr;
    b_acc  = n_acc;
  endtask

  task automatic send_bit(input logic b);
    line = b;
    step(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (WITH_PAR) send_bit((^d) ^ PARITY_ODD ^ par_flip);
    send_bit(stop_v);
  endtask

  int exp_err = 0;

  initial begin
    // reset state
    step(3);
    check_eq("rst_data", 32'(data_o), 32'h00);
    check_eq("rst_valid", 32'(valid_o), 32'h0);
    check_eq("rst_ferr", 32'(frame_err_o), 32'h0);
    check_eq("rst_perr", 32'(parity_err_o), 32'h0);
    check_eq("rst_ovr", 32'(overrun_o), 32'h0);
    check_eq("rst_cnt", 32'(err_cnt_o), 32'h0);
    check_eq("rst_busy", 32'(busy_o), 32'h0);
    reset_n = 1'b1;
    step(20);

    // single byte, consumer ready
    ready = 1'b1;
    snap();
    send_frame(8'hA5, 1'b1, 1'b0);
    line = 1'b1;
    step(20);
    check_eq("a5_acc", 32'(n_acc - b_acc), 32'd1);
    check_eq("a5_data", 32'(last_acc), 32'hA5);
    check_eq("a5_errs", 32'((n_ferr - b_ferr) + (n_perr - b_perr) + (n_ovr - b_ovr)), 32'd0);
    check_eq("a5_cnt", 32'(err_cnt_o), 32'd0);
    check_eq("a5_valid", 32'(valid_o), 32'h0);
    check_eq("a5_busy", 32'(busy_o), 32'h0);

    // back-to-back with consumer stalled: second byte overruns
    ready = 1'b0;
    snap();
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'h7E, 1'b1, 1'b0);
    line = 1'b1;
    step(20);
    exp_err = exp_err + 1;
    check_eq("ovr_valid", 32'(valid_o), 32'h1);
    check_eq("ovr_data", 32'(data_o), 32'h3C);
    check_eq("ovr_pulses", 32'(n_ovr - b_ovr), 32'd1);
    check_eq("ovr_cnt", 32'(err_cnt_o), 32'(exp_err));
    ready = 1'b1;
    step(2);
    check_eq("ovr_acc", 32'(n_acc - b_acc), 32'd1);
    check_eq("ovr_acc_data", 32'(last_acc), 32'h3C);
    check_eq("ovr_valid_clr", 32'(valid_o), 32'h0);

    // stop bit low, then line held low as a break
    snap();
    send_frame(8'h55, 1'b0, 1'b0);
    step(40);
    exp_err = exp_err + 1;
    check_eq("brk_ferr", 32'(n_ferr - b_ferr), 32'd1);
    check_eq("brk_busy", 32'(busy_o), 32'h1);
    line = 1'b1;
    step(20);
    check_eq("brk_idle", 32'(busy_o), 32'h0);
    check_eq("brk_noacc", 32'(n_acc - b_acc), 32'd0);
    check_eq("brk_ferr_once", 32'(n_ferr - b_ferr), 32'd1);
    check_eq("brk_cnt", 32'(err_cnt_o), 32'(exp_err));

    // short low glitch on idle line
    snap();
    line = 1'b0;
    step(4);
    line = 1'b1;
    step(2);
    check_eq("glitch_busy", 32'(busy_o), 32'h1);
    step(30);
    check_eq("glitch_idle", 32'(busy_o), 32'h0);
    check_eq("glitch_pulses", 32'((n_ferr - b_ferr) + (n_perr - b_perr) + (n_ovr - b_ovr)), 32'd0);
    check_eq("glitch_noacc", 32'(n_acc - b_acc), 32'd0);
    check_eq("glitch_cnt", 32'(err_cnt_o), 32'(exp_err));

`ifdef RS485_PARITY_EN
    // wrong parity then correct parity
    snap();
    send_frame(8'h81, 1'b1, 1'b1);
    line = 1'b1;
    step(20);
    exp_err = exp_err + 1;
    check_eq("par_bad_perr", 32'(n_perr - b_perr), 32'd1);
    check_eq("par_bad_noacc", 32'(n_acc - b_acc), 32'd0);
    check_eq("par_bad_cnt", 32'(err_cnt_o), 32'(exp_err));
    send_frame(8'h81, 1'b1, 1'b0);
    line = 1'b1;
    step(20);
    check_eq("par_ok_acc", 32'(n_acc - b_acc), 32'd1);
    check_eq("par_ok_data", 32'(last_acc), 32'h81);
`endif

    // reset in the middle of data bit 4 of 0xF0
    snap();
    line = 1'b0;
    step(80);
    line = 1'b1;
    step(8);
    check_eq("midrst_busy_pre", 32'(busy_o), 32'h1);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_busy", 32'(busy_o), 32'h0);
    check_eq("midrst_data", 32'(data_o), 32'h00);
    check_eq("midrst_cnt", 32'(err_cnt_o), 32'h0);
    step(3);
    reset_n = 1'b1;
    step(20);
    send_frame(8'h12, 1'b1, 1'b0);
    line = 1'b1;
    step(20);
    check_eq("midrst_acc", 32'(n_acc - b_acc), 32'd1);
    check_eq("midrst_acc_data", 32'(last_acc), 32'h12);
    check_eq("midrst_noferr", 32'(n_ferr - b_ferr), 32'd0);

    // counter saturation, preloaded near the top
    force dut.err_cnt_r = 16'hFFFD;
    #1;
    release dut.err_cnt_r;
    for (int k = 0; k < 3; k++) begin
      send_frame(8'h00, 1'b0, 1'b0);
      line = 1'b1;
      step(20);
      if (k == 0) check_eq("sat_fffe", 32'(err_cnt_o), 32'hFFFE);
      else        check_eq("sat_ffff", 32'(err_cnt_o), 32'hFFFF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
